prefix_sum_stage: RTL and testbench



---
 rtl/prefix_sum_stage.sv | 132 +++++++++++++
 tb/tb_prefix_sum_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_sum_stage.sv
// prefix_sum_stage
//   Final stage of the parallel-prefix adder. Forms the carries from the
//   prefix tree's group generate/propagate terms and the carry-in, then the
//   sum, carry-out and signed overflow. Results go through a 2-entry output
//   queue with valid/ready handshakes on both sides. The stage also keeps a
//   sticky overflow flag and a wrapping count of accepted operations.
//
// Ports
//   clk                    rising-edge clock
//   rst_n                  synchronous active-low reset
//   in_valid / in_ready    upstream handshake (in_ready from registered count)
//   half_sum_vector        p[i] = a[i] ^ b[i]
//   group_generate_vector  G[i:0] from the prefix tree
//   group_propagate_vector P[i:0] from the prefix tree
//   carry_in               adder carry-in
//   out_valid / out_ready  downstream handshake (out_valid from registered count)
//   sum_out                sum at queue head (0 when queue empty)
//   carry_out              carry-out at queue head (0 when queue empty)
//   overflow_out           signed overflow at queue head (0 when queue empty)
//   clear_status           clears overflow_sticky and op_count
//   overflow_sticky        set by any accepted op that overflowed
//   op_count               accepted-operation counter, wraps
module prefix_sum_stage #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] half_sum_vector,
    input  logic [WIDTH-1:0] group_generate_vector,
    input  logic [WIDTH-1:0] group_propagate_vector,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out,
    input  logic             clear_status,
    output logic             overflow_sticky,
    output logic [CNT_W-1:0] op_count
);

    // Queue entry layout: {sum, carry_out, overflow}
    localparam int ENTRY_W = WIDTH + 2;

    logic [WIDTH:0]                carry;
    logic [WIDTH-1:0]              new_sum;
    logic                          new_carry_out;
    logic                          new_overflow;

    logic [1:0][ENTRY_W-1:0]       q_data;
    logic [1:0]                    q_count;
    logic                          wr_ptr;
    logic                          rd_ptr;
    logic [ENTRY_W-1:0]            head;

    logic                          accept;
    logic                          pop;

    logic                          sticky_q;
    logic [CNT_W-1:0]              count_q;

    // The prefix tree already resolved every group term, so each carry is
    // one AND-OR level deep: c[i+1] = G[i:0] | (P[i:0] & cin).
    assign carry[0]       = carry_in;
    assign carry[WIDTH:1] = group_generate_vector
                          | (group_propagate_vector & {WIDTH{carry_in}});

    assign new_sum       = half_sum_vector ^ carry[WIDTH-1:0];
    assign new_carry_out = carry[WIDTH];
    assign new_overflow  = carry[WIDTH] ^ carry[WIDTH-1];

    // Handshake flags depend only on the registered occupancy, so there is
    // no combinational path from in_valid or out_ready.
    assign in_ready  = (q_count != 2'd2);
    assign out_valid = (q_count != 2'd0);

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_data  <= '0;
            q_count <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
        end else begin
            if (accept) begin
                q_data[wr_ptr] <= {new_sum, new_carry_out, new_overflow};
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Accept and pop together leave the occupancy unchanged.
            unique case ({accept, pop})
                2'b10:   q_count <= q_count + 2'd1;
                2'b01:   q_count <= q_count - 2'd1;
                default: q_count <= q_count;
            endcase
        end
    end

    // clear_status wins over a same-cycle set/increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else if (clear_status) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else if (accept) begin
            if (new_overflow) begin
                sticky_q <= 1'b1;
            end
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign head = q_data[rd_ptr];

    // Head fields are forced to 0 while the queue is empty.
    assign sum_out      = out_valid ? head[ENTRY_W-1:2] : '0;
    assign carry_out    = out_valid ? head[1]           : 1'b0;
    assign overflow_out = out_valid ? head[0]           : 1'b0;

    assign overflow_sticky = sticky_q;
    assign op_count        = count_q;

endmodule

// File: tb/tb_prefix_sum_stage.sv
module tb_prefix_sum_stage;

    localparam int WIDTH = 7;
    localparam int CNT_W = 4;   // small counter so the wrap is reachable

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] half_sum_vector;
    logic [WIDTH-1:0] group_generate_vector;
    logic [WIDTH-1:0] group_propagate_vector;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             overflow_out;
    logic             clear_status;
    logic             overflow_sticky;
    logic [CNT_W-1:0] op_count;

    prefix_sum_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .half_sum_vector        (half_sum_vector),
        .group_generate_vector  (group_generate_vector),
        .group_propagate_vector (group_propagate_vector),
        .carry_in               (carry_in),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .sum_out                (sum_out),
        .carry_out              (carry_out),
        .overflow_out           (overflow_out),
        .clear_status           (clear_status),
        .overflow_sticky        (overflow_sticky),
        .op_count               (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] pp;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    vec_t             vecs [8];
    int               checks;
    int               errors;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_sticky;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input int idx);
        half_sum_vector        = vecs[idx].p;
        group_generate_vector  = vecs[idx].g;
        group_propagate_vector = vecs[idx].pp;
        carry_in               = vecs[idx].cin;
    endtask

    task automatic scramble();
        half_sum_vector        = WIDTH'($urandom);
        group_generate_vector  = WIDTH'($urandom);
        group_propagate_vector = WIDTH'($urandom);
        carry_in               = 1'($urandom);
    endtask

    task automatic expect_head(input string name, input int idx);
        check(name, {22'd0, out_valid, sum_out, carry_out, overflow_out},
              {22'd0, 1'b1, vecs[idx].sum, vecs[idx].cout, vecs[idx].ovf});
    endtask

    task automatic expect_idle_outputs(input string name);
        check(name, {23'd0, out_valid, sum_out, carry_out, overflow_out}, 32'd0);
    endtask

    initial begin
        // Hand-derived vectors (a, b in comments); G/P are prefix-tree values.
        vecs[0] = '{7'h06, 7'h07, 7'h00, 1'b0, 7'h08, 1'b0, 1'b0}; // 05+03
        vecs[1] = '{7'h3E, 7'h3F, 7'h00, 1'b0, 7'h40, 1'b0, 1'b1}; // 3F+01
        vecs[2] = '{7'h7F, 7'h00, 7'h7F, 1'b1, 7'h00, 1'b1, 1'b0}; // 7F+00+1
        vecs[3] = '{7'h00, 7'h40, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1}; // 40+40
        vecs[4] = '{7'h3F, 7'h00, 7'h3F, 1'b0, 7'h3F, 1'b0, 1'b0}; // 2A+15
        vecs[5] = '{7'h3F, 7'h00, 7'h3F, 1'b1, 7'h40, 1'b0, 1'b1}; // 2A+15+1
        vecs[6] = '{7'h00, 7'h7F, 7'h00, 1'b0, 7'h7E, 1'b1, 1'b0}; // 7F+7F
        vecs[7] = '{7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 1'b0}; // 00+00

        checks       = 0;
        errors       = 0;
        exp_cnt      = '0;
        exp_sticky   = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        clear_status = 1'b0;
        scramble();

        repeat (3) step();
        expect_idle_outputs("reset_head");
        check("reset_sticky", {31'd0, overflow_sticky}, 32'd0);
        check("reset_count", {28'd0, op_count}, 32'd0);
        rst_n = 1'b1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Table: one op at a time, popped the cycle after it appears.
        for (int i = 0; i < 8; i++) begin
            drive_op(i);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            scramble();
            exp_cnt = exp_cnt + 1'b1;
            if (vecs[i].ovf) exp_sticky = 1'b1;
            expect_head($sformatf("vec%0d_head", i), i);
            check($sformatf("vec%0d_count", i), {28'd0, op_count}, {28'd0, exp_cnt});
            check($sformatf("vec%0d_sticky", i), {31'd0, overflow_sticky}, {31'd0, exp_sticky});
            step();
            check($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
        end

        // Sticky held through the later non-overflow ops; clear it.
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        exp_cnt = '0;
        check("clear_sticky", {31'd0, overflow_sticky}, 32'd0);
        check("clear_count", {28'd0, op_count}, 32'd0);

        // Backpressure: three ops offered, only two fit.
        out_ready = 1'b0;
        drive_op(0);
        in_valid = 1'b1;
        step();
        check("bp_ready_after1", {31'd0, in_ready}, 32'd1);
        drive_op(2);
        step();
        check("bp_ready_after2", {31'd0, in_ready}, 32'd0);
        drive_op(4);
        step();
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        expect_head("bp_head_a", 0);
        step();
        expect_head("bp_head_stable", 0);
        exp_cnt = exp_cnt + 2'd2;
        check("bp_count2", {28'd0, op_count}, {28'd0, exp_cnt});
        out_ready = 1'b1;
        step();
        expect_head("bp_head_b", 2);
        check("bp_ready_reopen", {31'd0, in_ready}, 32'd1);
        check("bp_third_not_taken", {28'd0, op_count}, {28'd0, exp_cnt});
        step();
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        expect_head("bp_head_c", 4);
        check("bp_count3", {28'd0, op_count}, {28'd0, exp_cnt});
        step();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Streaming at occupancy 1: accept and pop every cycle.
        drive_op(0);
        in_valid = 1'b1;
        step();
        exp_cnt = exp_cnt + 1'b1;
        expect_head("stream_first", 0);
        for (int k = 1; k <= 10; k++) begin
            drive_op(k % 8);
            step();
            exp_cnt = exp_cnt + 1'b1;
            expect_head($sformatf("stream%0d_head", k), k % 8);
            check($sformatf("stream%0d_ready", k), {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        check("stream_count", {28'd0, op_count}, {28'd0, exp_cnt});
        step();
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        // Two more accepts take the 4-bit counter from 14 through 15 to 0.
        out_ready = 1'b0;
        drive_op(5);
        in_valid = 1'b1;
        step();
        drive_op(6);
        step();
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 2'd2;
        check("wrap_count", {28'd0, op_count}, {28'd0, exp_cnt});
        expect_head("wrap_head", 5);
        out_ready = 1'b1;
        step();
        expect_head("wrap_head2", 6);
        step();
        check("wrap_drained", {31'd0, out_valid}, 32'd0);

        // clear_status in the same cycle as an overflowing accept.
        out_ready    = 1'b0;
        drive_op(1);
        in_valid     = 1'b1;
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("clracc_count", {28'd0, op_count}, 32'd0);
        check("clracc_sticky", {31'd0, overflow_sticky}, 32'd0);
        expect_head("clracc_queued", 1);
        drive_op(3);
        step();
        in_valid = 1'b0;
        check("postclr_count", {28'd0, op_count}, 32'd1);
        check("postclr_sticky", {31'd0, overflow_sticky}, 32'd1);
        check("postclr_full", {31'd0, in_ready}, 32'd0);

        // Reset with two entries queued flushes everything.
        out_ready = 1'b1;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        expect_idle_outputs("midrst_head");
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_count", {28'd0, op_count}, 32'd0);
        check("midrst_sticky", {31'd0, overflow_sticky}, 32'd0);

        // The stage works normally after the flush.
        drive_op(6);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        expect_head("postrst_head", 6);
        step();
        check("postrst_drained", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
